// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: IDLE grant, EXEC capture, RESP handshake.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module alu_arbiter #(
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [4*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_x,
   input  logic [32*NREQ-1:0]   req_y,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_data,
   output logic                 rsp_zero,
   output logic [3:0]           alu_op,
   output logic [31:0]          alu_x,
   output logic [31:0]          alu_y,
   input  logic [31:0]          alu_s,
   input  logic                 alu_zr
);

   localparam int          GNT_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned NREQ_U = NREQ;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [GNT_W-1:0] gnt_q, gnt_d;
   logic [GNT_W-1:0] win;
   logic             any_valid;
   logic [3:0]       alu_op_q, alu_op_d;
   logic [31:0]      alu_x_q, alu_x_d;
   logic [31:0]      alu_y_q, alu_y_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic             rsp_zero_q, rsp_zero_d;

`ifdef ALU_ARB_RR_EN
   logic [GNT_W-1:0] rr_ptr_q, rr_ptr_d;
   int unsigned      rr_idx;

   // Search starts at rr_ptr and wraps modulo NREQ; first valid wins.
   always_comb begin
      win       = '0;
      any_valid = 1'b0;
      rr_idx    = 0;
      for (int unsigned k = 0; k < NREQ_U; k++) begin
         rr_idx = 32'(rr_ptr_q) + k;
         if (rr_idx >= NREQ_U) rr_idx = rr_idx - NREQ_U;
         if (!any_valid && req_valid[rr_idx]) begin
            any_valid = 1'b1;
            win       = GNT_W'(rr_idx);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == S_IDLE && any_valid) begin
         rr_ptr_d = (win == GNT_W'(NREQ_U - 1)) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end
`else
   always_comb begin
      win       = '0;
      any_valid = 1'b0;
      for (int unsigned k = 0; k < NREQ_U; k++) begin
         if (!any_valid && req_valid[k]) begin
            any_valid = 1'b1;
            win       = GNT_W'(k);
         end
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      alu_op_d   = alu_op_q;
      alu_x_d    = alu_x_q;
      alu_y_d    = alu_y_q;
      rsp_data_d = rsp_data_q;
      rsp_zero_d = rsp_zero_q;
      case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               state_d  = S_EXEC;
               gnt_d    = win;
               alu_op_d = req_op[32'(win)*4 +: 4];
               alu_x_d  = req_x[32'(win)*32 +: 32];
               alu_y_d  = req_y[32'(win)*32 +: 32];
            end
         end
         S_EXEC: begin
            rsp_data_d = alu_s;
            rsp_zero_d = alu_zr;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready[gnt_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int unsigned k = 0; k < NREQ_U; k++) begin
         req_ready[k] = (state_q == S_IDLE) && any_valid && (win == GNT_W'(k));
         rsp_valid[k] = (state_q == S_RESP) && (gnt_q == GNT_W'(k));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         gnt_q      <= '0;
         alu_op_q   <= '0;
         alu_x_q    <= '0;
         alu_y_q    <= '0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         alu_op_q   <= alu_op_d;
         alu_x_q    <= alu_x_d;
         alu_y_q    <= alu_y_d;
         rsp_data_q <= rsp_data_d;
         rsp_zero_q <= rsp_zero_d;
      end
   end

   assign alu_op   = alu_op_q;
   assign alu_x    = alu_x_q;
   assign alu_y    = alu_y_q;
   assign rsp_data = rsp_data_q;
   assign rsp_zero = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: acts as the shared ALU and as the requesters, checks against a transaction-level model.
module tb_alu_arbiter;

   localparam int NREQ = 4;

   logic                 clk;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [4*NREQ-1:0]    req_op;
   logic [32*NREQ-1:0]   req_x;
   logic [32*NREQ-1:0]   req_y;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ-1:0]      rsp_ready;
   logic [31:0]          rsp_data;
   logic                 rsp_zero;
   logic [3:0]           alu_op;
   logic [31:0]          alu_x;
   logic [31:0]          alu_y;
   logic [31:0]          alu_s;
   logic                 alu_zr;

   logic [NREQ-1:0]      f_valid;
   logic [3:0]           f_op [NREQ];
   logic [31:0]          f_x  [NREQ];
   logic [31:0]          f_y  [NREQ];

   int checks   = 0;
   int failures = 0;
   int m_ptr    = 0;

   alu_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_x(req_x), .req_y(req_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero),
      .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
      .alu_s(alu_s), .alu_zr(alu_zr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      case (op)
         4'b0000: return x & y;
         4'b0001: return x | y;
         4'b0010: return x + y;
         4'b0110: return x - y;
         default: return x;
      endcase
   endfunction

   always_comb begin
      alu_s  = alu_ref(alu_op, alu_x, alu_y);
      alu_zr = (alu_s == 32'd0);
   end

   always_comb begin
      req_valid = f_valid;
      req_op    = '0;
      req_x     = '0;
      req_y     = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_op[4*i +: 4]  = f_op[i];
         req_x[32*i +: 32] = f_x[i];
         req_y[32*i +: 32] = f_y[i];
      end
   end

   function automatic logic [NREQ-1:0] oh(input int g);
      logic [NREQ-1:0] v;
      v = '0;
      v[g] = 1'b1;
      return v;
   endfunction

   // Arbitration rule: first valid requester starting from ptr, wrapping.
   function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_x", alu_x, 32'd0);
      chk("rst_alu_y", alu_y, 32'd0);
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      f_op[i]    = op;
      f_x[i]     = x;
      f_y[i]     = y;
      f_valid[i] = 1'b1;
   endtask

   // Called at posedge+1 of an IDLE cycle with requests driven; returns at posedge+1 of the next IDLE cycle.
   task automatic txn(input int bp, input bit drop, output int got_g);
      int          g;
      logic [3:0]  eop;
      logic [31:0] ex, ey, er;
      logic        ez;
      #1;
      g = pick(f_valid, m_ptr);
      got_g = -1;
      for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i] === 1'b1) got_g = i;
      if (g < 0) begin
         chk("txn_no_request", 32'(req_ready), 32'd0);
         return;
      end
      chk("idle_req_ready", 32'(req_ready), 32'(oh(g)));
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      eop = f_op[g];
      ex  = f_x[g];
      ey  = f_y[g];
      er  = alu_ref(eop, ex, ey);
      ez  = (er == 32'd0);
`ifdef ALU_ARB_RR_EN
      m_ptr = (g + 1) % NREQ;
`endif
      step();
      if (drop) f_valid[g] = 1'b0;
      #1;
      chk("exec_req_ready", 32'(req_ready), 32'd0);
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_alu_op", 32'(alu_op), 32'(eop));
      chk("exec_alu_x", alu_x, ex);
      chk("exec_alu_y", alu_y, ey);
      step();
      for (int c = 0; c < bp; c++) begin
         rsp_ready = ~oh(g);
         #1;
         chk("bp_rsp_valid", 32'(rsp_valid), 32'(oh(g)));
         chk("bp_rsp_data", rsp_data, er);
         chk("bp_rsp_zero", 32'(rsp_zero), 32'(ez));
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         step();
      end
      rsp_ready = oh(g);
      #1;
      chk("resp_rsp_valid", 32'(rsp_valid), 32'(oh(g)));
      chk("resp_rsp_data", rsp_data, er);
      chk("resp_rsp_zero", 32'(rsp_zero), 32'(ez));
      chk("resp_req_ready", 32'(req_ready), 32'd0);
      step();
      rsp_ready = '0;
   endtask

   initial begin
      int g;
      int order [5];
`ifdef ALU_ARB_RR_EN
      order = '{0, 1, 2, 3, 0};
`else
      order = '{0, 0, 0, 0, 0};
`endif
      reset     = 1'b1;
      f_valid   = '0;
      rsp_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         f_op[i] = '0;
         f_x[i]  = '0;
         f_y[i]  = '0;
      end
      repeat (3) step();
      chk_reset_vals();
      reset = 1'b0;
      step();

      // Single ADD from requester 0.
      set_req(0, 4'b0010, 32'd5, 32'd7);
      txn(0, 1'b1, g);
      chk("t1_grant", 32'(g), 32'd0);
      chk("t1_data", rsp_data, 32'd12);
      chk("t1_zero", 32'(rsp_zero), 32'd0);

      // SUB zero result, SUB wrap, pass-X.
      set_req(1, 4'b0110, 32'd9, 32'd9);
      txn(0, 1'b1, g);
      chk("t2_sub_data", rsp_data, 32'd0);
      chk("t2_sub_zero", 32'(rsp_zero), 32'd1);
      set_req(1, 4'b0110, 32'd0, 32'd1);
      txn(0, 1'b1, g);
      chk("t2_wrap_data", rsp_data, 32'hFFFF_FFFF);
      set_req(1, 4'b1111, 32'h0000_00A5, 32'h1234_5678);
      txn(0, 1'b1, g);
      chk("t2_pass_data", rsp_data, 32'h0000_00A5);

      // Reset during EXEC.
      set_req(0, 4'b0010, 32'd1, 32'd2);
      step();
      reset   = 1'b1;
      f_valid = '0;
      step();
      reset = 1'b0;
      m_ptr = 0;
      #1;
      chk_reset_vals();
      step();
      chk("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);

      // Reset during RESP while the response is held off.
      set_req(2, 4'b0001, 32'hF0, 32'h0F);
      step();
      f_valid = '0;
      step();
      chk("rst_resp_pre_valid", 32'(rsp_valid), 32'(oh(2)));
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_ptr = 0;
      #1;
      chk_reset_vals();
      step();
      chk("rst_resp_no_rsp", 32'(rsp_valid), 32'd0);

      // All requesters held valid continuously.
      for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
      for (int n = 0; n < 5; n++) begin
         txn(0, 1'b0, g);
         chk("t3_order", 32'(g), 32'(order[n]));
      end
      f_valid = '0;

      // Backpressure on requester 2, then requests from 1 and 3 right after the handshake.
      set_req(2, 4'b0000, 32'hDEAD_BEEF, 32'h0FF0_0FF0);
      txn(5, 1'b1, g);
      set_req(1, 4'b0010, 32'hFFFF_FFFF, 32'd2);
      set_req(3, 4'b0110, 32'd100, 32'd58);
      #1;
      chk("t6_one_ready", 32'($countones(req_ready)), 32'd1);
      txn(0, 1'b1, g);
      txn(0, 1'b1, g);

      // Randomized traffic.
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!f_valid[i] && ($urandom_range(0, 1) == 1)) set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
         end
         if (f_valid == '0) set_req($urandom_range(0, NREQ - 1), 4'b0110, $urandom, $urandom);
         txn($urandom_range(0, 3), 1'b1, g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
